// File: rtl/requant_pkg.sv
// Shared constants for the requantisation pipeline.
// Build option REQUANT_RELU_EN enables the per-beat ReLU clamp.
package requant_pkg;

  localparam int LANES_DEF   = 4;
  localparam int IN_W_DEF    = 32;
  localparam int OUT_W_DEF   = 8;
  localparam int SHIFT_W_DEF = 5;
  localparam int SAT_CNT_W   = 16;

`ifdef REQUANT_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

endpackage

// File: rtl/requant_lane.sv
// One lane: round-half-up arithmetic shift into the S1 register,
// saturating clip (optionally ReLU) into the S2 register.
module requant_lane
  import requant_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               s1_load_i,
  input  logic               s2_load_i,
  input  logic [IN_W-1:0]    x_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               relu_i,
  output logic [OUT_W-1:0]   out_o,
  output logic               clip_o
);

  localparam int YW = IN_W + 1;
  localparam logic signed [YW-1:0] Y_MAX = YW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [YW-1:0] Y_MIN = ~Y_MAX;

  logic signed [YW-1:0] x_ext, bias, sum, y_d, y_q;
  logic [OUT_W-1:0]     out_d, out_q;

  // One extra bit of headroom so adding the rounding bias never overflows.
  always_comb begin
    x_ext = {x_i[IN_W-1], x_i};
    bias  = '0;
    if (shift_i != '0) bias = {{(YW-1){1'b0}}, 1'b1} << (shift_i - 1'b1);
    sum = x_ext + bias;
    y_d = sum >>> shift_i;
  end

  always_comb begin
    out_d  = y_q[OUT_W-1:0];
    clip_o = 1'b0;
    if (y_q > Y_MAX) begin
      out_d  = Y_MAX[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (y_q < Y_MIN) begin
      if (relu_i) begin
        out_d = '0;
      end else begin
        out_d  = Y_MIN[OUT_W-1:0];
        clip_o = 1'b1;
      end
    end else if (relu_i && y_q[YW-1]) begin
      out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      y_q   <= '0;
      out_q <= '0;
    end else begin
      if (s1_load_i) y_q <= y_d;
      if (s2_load_i) out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/requant_pipe.sv
// Two-stage requantisation pipeline with valid/ready handshakes and a
// saturating clip counter. ReLU is honoured only when REQUANT_RELU_EN is defined.
module requant_pipe
  import requant_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [SHIFT_W-1:0]     shift,
  input  logic                   relu_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  input  logic                   sat_clr,
  output logic [SAT_CNT_W-1:0]   sat_cnt
);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic                 s1_relu_q;
  logic                 s1_adv, s1_load, s2_load;
  logic [LANES-1:0]     clip;
  logic [SAT_CNT_W-1:0] sat_q, sat_d;
  logic [SAT_CNT_W:0]   clip_sum, sat_sum;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s1_adv;

  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;

    clip_sum = '0;
    for (int k = 0; k < LANES; k++) clip_sum = clip_sum + {{SAT_CNT_W{1'b0}}, clip[k]};
    sat_sum = {1'b0, sat_q} + clip_sum;

    // Clear has priority over the count of the beat entering S2.
    sat_d = sat_q;
    if (sat_clr) sat_d = '0;
    else if (s2_load) sat_d = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_relu_q  <= 1'b0;
      sat_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) s1_relu_q <= relu_en & RELU_ON;
      sat_q <= sat_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    requant_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk       (clk),
      .rst_b     (rst_b),
      .s1_load_i (s1_load),
      .s2_load_i (s2_load),
      .x_i       (in_data[k*IN_W +: IN_W]),
      .shift_i   (shift),
      .relu_i    (s1_relu_q),
      .out_o     (out_data[k*OUT_W +: OUT_W]),
      .clip_o    (clip[k])
    );
  end

  assign out_valid = s2_valid_q;
  assign sat_cnt   = sat_q;

endmodule
